// File: rtl/ifetch.sv
// Instruction fetch unit: a three-state request/hold engine between program memory
// and the control unit, with a redirect (jump) path that overrides capture and consumption.
module ifetch #(
  parameter int          ADDR_W  = 8,
  parameter logic [3:0]  S_FETCH = 4'd0,
  parameter logic [3:0]  NOP     = 4'b0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        state,
  input  logic              run,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        instruction,
  output logic [3:0]        operand,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [ADDR_W-1:0] pc
);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_FULL = 2'd2
  } fetch_state_e;

  fetch_state_e      fsm_q, fsm_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic [7:0]        word_q, word_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    fsm_d      = fsm_q;
    pc_d       = pc_q;
    instr_pc_d = instr_pc_q;
    word_d     = word_q;

    if (jump) begin
      // Redirect wins over capture and consumption; read data on this edge is dropped.
      pc_d  = jump_addr;
      fsm_d = run ? F_REQ : F_IDLE;
    end else begin
      unique case (fsm_q)
        F_IDLE: begin
          if (run) fsm_d = F_REQ;
        end
        F_REQ: begin
          // An outstanding request completes even if run falls meanwhile.
          if (mem_ready) begin
            word_d     = mem_rdata;
            instr_pc_d = pc_q;
            pc_d       = pc_q + ADDR_W'(1);
            fsm_d      = F_FULL;
          end
        end
        F_FULL: begin
          if (state == S_FETCH) fsm_d = run ? F_REQ : F_IDLE;
        end
        default: fsm_d = F_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fsm_q      <= F_IDLE;
      pc_q       <= '0;
      instr_pc_q <= '0;
      // NOTE: the word register is reset even though outputs are gated, keeping state deterministic.
      word_q     <= '0;
    end else begin
      fsm_q      <= fsm_d;
      pc_q       <= pc_d;
      instr_pc_q <= instr_pc_d;
      word_q     <= word_d;
    end
  end

  assign mem_req     = (fsm_q == F_REQ);
  assign instr_valid = (fsm_q == F_FULL);
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instr_pc    = instr_pc_q;
  assign instruction = instr_valid ? word_q[7:4] : NOP;
  assign operand     = instr_valid ? word_q[3:0] : 4'h0;

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: a scoreboard queue holds the words each capture should deliver,
// a monitor pops on every new held word, and the stimulus thread checks control-side outputs.
module tb_ifetch;

  localparam int         ADDR_W  = 8;
  localparam logic [3:0] S_FETCH = 4'd0;
  localparam logic [3:0] NOP     = 4'b0000;
  localparam logic [3:0] S_EXEC  = 4'd1;

  typedef struct packed {
    logic [7:0] pc;
    logic [7:0] word;
  } exp_t;

  logic              clock;
  logic              reset;
  logic [3:0]        state;
  logic              run;
  logic              jump;
  logic [ADDR_W-1:0] jump_addr;
  logic [7:0]        mem_rdata;
  logic              mem_ready;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        instruction;
  logic [3:0]        operand;
  logic              instr_valid;
  logic [ADDR_W-1:0] instr_pc;
  logic [ADDR_W-1:0] pc;

  logic [7:0] mem [256];
  exp_t       sb_q [$];
  int         total = 0;
  int         bad   = 0;

  ifetch #(.ADDR_W(ADDR_W), .S_FETCH(S_FETCH), .NOP(NOP)) dut (
    .clock       (clock),
    .reset       (reset),
    .state       (state),
    .run         (run),
    .jump        (jump),
    .jump_addr   (jump_addr),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .instruction (instruction),
    .operand     (operand),
    .instr_valid (instr_valid),
    .instr_pc    (instr_pc),
    .pc          (pc)
  );

  assign mem_rdata = mem[mem_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] a);
    exp_t e;
    e.pc   = a;
    e.word = mem[a];
    sb_q.push_back(e);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"},     32'(mem_req),     32'd0);
    check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instruction"}, 32'(instruction), 32'(NOP));
    check({tag, "_operand"},     32'(operand),     32'd0);
    check({tag, "_pc"},          32'(pc),          32'd0);
    check({tag, "_instr_pc"},    32'(instr_pc),    32'd0);
  endtask

  // Monitor: every rising instr_valid is a freshly captured word.
  initial begin : monitor
    logic last_valid;
    exp_t e;
    last_valid = 1'b0;
    forever begin
      @(negedge clock);
      if (reset && instr_valid && !last_valid) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: word pc=%0h op=%0h opd=%0h with nothing expected",
                   instr_pc, instruction, operand);
        end else begin
          e = sb_q.pop_front();
          check("sb_instr_pc",   32'(instr_pc),    32'(e.pc));
          check("sb_instruction", 32'(instruction), 32'(e.word[7:4]));
          check("sb_operand",    32'(operand),     32'(e.word[3:0]));
        end
      end
      last_valid = instr_valid;
    end
  end

  initial begin : stimulus
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h00] = 8'h35;
    mem[8'h01] = 8'hA7;
    mem[8'h40] = 8'h9C;
    mem[8'hFF] = 8'h6E;

    reset = 1'b0; run = 1'b0; jump = 1'b0; jump_addr = '0;
    state = S_EXEC; mem_ready = 1'b0;
    #2;
    check_reset_outputs("rst");
    repeat (2) @(negedge clock);

    // Release with run and memory always ready: first word at 0.
    run = 1'b1; mem_ready = 1'b1; reset = 1'b1;
    push(8'h00);
    @(negedge clock);
    check("boot_mem_req", 32'(mem_req), 32'd1);
    check("boot_mem_addr", 32'(mem_addr), 32'h00);
    check("boot_valid_low", 32'(instr_valid), 32'd0);
    @(negedge clock);
    check("boot_valid", 32'(instr_valid), 32'd1);
    check("boot_pc", 32'(pc), 32'h01);

    // Word held while the control unit is busy.
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      check("hold_instruction", 32'(instruction), 32'h3);
      check("hold_operand", 32'(operand), 32'h5);
      check("hold_no_req", 32'(mem_req), 32'd0);
    end
    state = S_FETCH;
    @(negedge clock);
    state = S_EXEC;
    check("consume_valid", 32'(instr_valid), 32'd0);
    check("consume_req", 32'(mem_req), 32'd1);
    check("consume_addr", 32'(mem_addr), 32'h01);

    // Memory stalls five cycles; run dropping must not abandon the request.
    run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("stall_req", 32'(mem_req), 32'd1);
      check("stall_addr", 32'(mem_addr), 32'h01);
      check("stall_nop", 32'(instruction), 32'(NOP));
    end
    run = 1'b1; mem_ready = 1'b1;
    push(8'h01);
    @(negedge clock);
    mem_ready = 1'b0;
    check("stall_capture_pc", 32'(pc), 32'h02);
    @(negedge clock);
    check("stall_once_pc", 32'(pc), 32'h02);

    // Consume, then jump on the same edge the memory answers.
    state = S_FETCH;
    @(negedge clock);
    state = S_EXEC;
    check("pre_jump_addr", 32'(mem_addr), 32'h02);
    jump = 1'b1; jump_addr = 8'h40; mem_ready = 1'b1;
    @(negedge clock);
    jump = 1'b0; mem_ready = 1'b0;
    check("jump_pc", 32'(pc), 32'h40);
    check("jump_valid", 32'(instr_valid), 32'd0);
    check("jump_req", 32'(mem_req), 32'd1);
    check("jump_addr_out", 32'(mem_addr), 32'h40);
    push(8'h40); mem_ready = 1'b1;
    @(negedge clock);
    check("tgt_pc", 32'(pc), 32'h41);

    // Jump beats consumption.
    state = S_FETCH; jump = 1'b1; jump_addr = 8'hFF; mem_ready = 1'b0;
    @(negedge clock);
    jump = 1'b0; state = S_EXEC;
    check("jc_valid", 32'(instr_valid), 32'd0);
    check("jc_pc", 32'(pc), 32'hFF);
    check("jc_req", 32'(mem_req), 32'd1);

    // Capture at the top of the address space wraps pc.
    push(8'hFF); mem_ready = 1'b1;
    @(negedge clock);
    check("wrap_pc", 32'(pc), 32'h00);
    check("wrap_instr_pc", 32'(instr_pc), 32'hFF);
    run = 1'b0; state = S_FETCH; mem_ready = 1'b0;
    @(negedge clock);
    check("idle_req", 32'(mem_req), 32'd0);
    check("idle_valid", 32'(instr_valid), 32'd0);
    check("idle_nop", 32'(instruction), 32'(NOP));
    @(negedge clock);
    check("idle_stay", 32'(mem_req), 32'd0);

    // Asynchronous reset in the middle of an outstanding request.
    run = 1'b1; state = S_EXEC; mem_ready = 1'b1;
    push(8'h00);
    @(negedge clock);
    check("r2_req", 32'(mem_req), 32'd1);
    @(negedge clock);
    state = S_FETCH; mem_ready = 1'b0;
    @(negedge clock);
    state = S_EXEC;
    check("r2_inflight_req", 32'(mem_req), 32'd1);
    check("r2_inflight_pc", 32'(pc), 32'h01);
    #2 reset = 1'b0;
    #1 check_reset_outputs("async");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("restart_req", 32'(mem_req), 32'd1);
    check("restart_addr", 32'(mem_addr), 32'h00);

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
